// File: rtl/ft600_sched.sv
`timescale 1ns/1ps
// FT600 245-mode bus scheduler: round-robin RX/TX bursts with a one-word TX holding register.
// Optional word statistics are enabled by defining FT600_SCHED_STATS_EN.
module ft600_sched #(
   parameter int DATA_WIDTH = 16,
   parameter int BE_WIDTH   = 2,
   parameter int MAX_BURST  = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  txe_n,
   input  logic                  rxf_n,
   output logic                  wr_n,
   output logic                  rd_n,
   output logic                  oe_n,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [BE_WIDTH-1:0]   be_out,
   output logic                  data_oe,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  tx_en,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_empty,
   output logic                  rx_en,
   output logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_full,
   output logic [31:0]           tx_words,
   output logic [31:0]           rx_words
);

   typedef enum logic [2:0] {IDLE, RX_OE, RX_READ, TX_WRITE, TURN} state_t;

   localparam logic        DIR_RX     = 1'b0;
   localparam logic        DIR_TX     = 1'b1;
   localparam logic [15:0] BURST_LAST = 16'(MAX_BURST - 1);

   state_t                 state_reg, state_next;
   logic [15:0]            burst_cnt_reg, burst_cnt_next;
   logic                   last_dir_reg, last_dir_next;
   logic [DATA_WIDTH-1:0]  hold_data_reg, hold_data_next;
   logic                   hold_valid_reg, hold_valid_next;
   logic                   fetch_reg;
   logic                   oe_n_reg, data_oe_reg, wr_n_reg;

   logic rx_req, tx_req;
   logic in_rx, in_tx;
   logic tx_accept, burst_last, tx_exit;

   always_comb begin
      rx_req     = !rxf_n && !rx_full;
      tx_req     = !txe_n && (hold_valid_reg || !tx_empty);
      in_rx      = (state_reg == RX_READ);
      in_tx      = (state_reg == TX_WRITE);
      burst_last = (burst_cnt_reg == BURST_LAST);

      rx_en      = in_rx && !rxf_n && !rx_full;
      tx_accept  = in_tx && hold_valid_reg && !txe_n;
      tx_exit    = in_tx && (txe_n || (tx_accept && burst_last) ||
                             (!hold_valid_reg && tx_empty && !fetch_reg));
      // Only one fetch may be outstanding, and only into a slot that is free by the next edge.
      tx_en      = in_tx && !tx_exit && !tx_empty && !fetch_reg &&
                   (!hold_valid_reg || tx_accept);

      state_next      = state_reg;
      burst_cnt_next  = burst_cnt_reg;
      last_dir_next   = last_dir_reg;
      hold_data_next  = hold_data_reg;
      hold_valid_next = hold_valid_reg;

      // A fetch lands even after the burst has ended, so the word waits for the next grant.
      if (fetch_reg) begin
         hold_data_next  = tx_data;
         hold_valid_next = 1'b1;
      end else if (tx_accept) begin
         hold_valid_next = 1'b0;
      end

      if (rx_en || tx_accept)
         burst_cnt_next = burst_cnt_reg + 16'd1;

      case (state_reg)
         IDLE: begin
            if (rx_req && (!tx_req || last_dir_reg == DIR_TX)) begin
               state_next     = RX_OE;
               burst_cnt_next = '0;
               last_dir_next  = DIR_RX;
            end else if (tx_req) begin
               state_next     = TX_WRITE;
               burst_cnt_next = '0;
               last_dir_next  = DIR_TX;
            end
         end
         RX_OE:    state_next = RX_READ;
         RX_READ: begin
            if (rxf_n || rx_full || (rx_en && burst_last))
               state_next = TURN;
         end
         TX_WRITE: begin
            if (tx_exit)
               state_next = TURN;
         end
         TURN:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         burst_cnt_reg  <= '0;
         last_dir_reg   <= DIR_TX;
         hold_data_reg  <= '0;
         hold_valid_reg <= 1'b0;
         fetch_reg      <= 1'b0;
         oe_n_reg       <= 1'b1;
         data_oe_reg    <= 1'b0;
         wr_n_reg       <= 1'b1;
      end else begin
         state_reg      <= state_next;
         burst_cnt_reg  <= burst_cnt_next;
         last_dir_reg   <= last_dir_next;
         hold_data_reg  <= hold_data_next;
         hold_valid_reg <= hold_valid_next;
         fetch_reg      <= tx_en;
         // Pad controls are registered from the next state so they change cleanly on clk.
         oe_n_reg       <= !(state_next == RX_OE || state_next == RX_READ);
         data_oe_reg    <= (state_next == TX_WRITE);
         wr_n_reg       <= !(state_next == TX_WRITE && hold_valid_next);
      end
   end

   assign oe_n     = oe_n_reg;
   assign data_oe  = data_oe_reg;
   assign wr_n     = wr_n_reg;
   assign rd_n     = in_rx ? rx_full : 1'b1;
   assign data_out = hold_data_reg;
   assign rx_data  = data_in;

   genvar gi;
   generate
      for (gi = 0; gi < BE_WIDTH; gi++) begin : g_be
         assign be_out[gi] = 1'b1;
      end
   endgenerate

`ifdef FT600_SCHED_STATS_EN
   logic [31:0] tx_words_reg, rx_words_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_words_reg <= '0;
         rx_words_reg <= '0;
      end else begin
         if (tx_accept)
            tx_words_reg <= tx_words_reg + 32'd1;
         if (rx_en)
            rx_words_reg <= rx_words_reg + 32'd1;
      end
   end

   assign tx_words = tx_words_reg;
   assign rx_words = rx_words_reg;
`else
   assign tx_words = '0;
   assign rx_words = '0;
`endif

endmodule
